bullet_fire_ctrl: RTL and testbench
===================================

// Module: bullet_fire_ctrl
// PURPOSE
//   Fire scheduler for a pool of NUM_SLOTS bullet instances. Watches the keyboard keycodes
//   for SPACE and enforces a frame cooldown and press/release arming. It allocates free
//   bullet slots round-robin, then issues a one-frame launch strobe with the latched ship
//   position. Sits between the keyboard/ship logic and the bullet instances; each bullet
//   reports its active flag back on slot_active.
// PARAMETERS
//   NUM_SLOTS   4      number of bullet instances managed (2..8)
//   COOLDOWN    6      frames spent in COOLDOWN after a launch (>=2)
//   Y_MIN       15     no launch unless ship_Y > Y_MIN
//   SPACE_CODE  8'h2c  keycode that requests fire
//   AUTO_REPEAT 0      1: holding SPACE refires every cooldown; 0: release required
// PORTS
//   frame_clk    in   1          frame clock; all state advances on posedge
//   Reset        in   1          asynchronous, active-high reset
//   keycode      in   24         three 8-bit keycodes {[23:16],[15:8],[7:0]}
//   ship_X       in   10         current ship X (launch origin)
//   ship_Y       in   10         current ship Y (launch origin)
//   slot_active  in   NUM_SLOTS  bit i = bullet i in flight
//   launch       out  NUM_SLOTS  one-hot, one-frame launch strobe to bullet i
//   launch_X     out  10         latched ship_X, valid while launch != 0
//   launch_Y     out  10         latched ship_Y, valid while launch != 0
//   fire_ready   out  1          1 in IDLE with at least one free slot
//   shots_fired  out  8          launch counter; wraps 255->0
// BEHAVIOUR
//   Reset (async): state=IDLE, launch=0, launch_X/Y=0, rr_ptr=0, armed=1,
//     cool_cnt=0, shots_fired=0. fire_ready follows comb from IDLE and slot_active after reset.
//     Reset mid-LAUNCH or mid-COOLDOWN drops launch to 0 immediately; no partial state is kept.
//   space = any keycode byte == SPACE_CODE. If AUTO_REPEAT=0, armed clears on each launch
//     and sets on any frame where space=0. If AUTO_REPEAT=1, armed is held at 1.
//   Free-slot search (comb): scan from rr_ptr upward with modulo NUM_SLOTS.
//     sel = first i with slot_active[i]=0. found=0 if every slot is active.
//   FSM, registered, one transition per frame_clk:
//     IDLE: if space & armed & found & ship_Y>Y_MIN -> LAUNCH.
//           On that edge: launch<=onehot(sel), launch_X<=ship_X, launch_Y<=ship_Y,
//           rr_ptr<=(sel+1)%NUM_SLOTS, shots_fired++, armed<=0 (if AUTO_REPEAT=0).
//           Otherwise stay in IDLE; launch stays 0.
//     LAUNCH: exactly one frame. Next edge: launch<=0, cool_cnt<=COOLDOWN-1 -> COOLDOWN.
//     COOLDOWN: cool_cnt decrements each frame; at cool_cnt==0 -> IDLE. Space is ignored here.
//   Latency: qualifying request sampled at edge N gives launch high for N..N+1.
//     Earliest next launch is at edge N+1+COOLDOWN.
//   Comparisons: ship_Y>Y_MIN is unsigned 10-bit. rr_ptr is $clog2(NUM_SLOTS) bits, explicit modulo.
//   All slots busy + space held: stay IDLE and keep armed. Launch fires on the first frame
//     a slot frees, including with AUTO_REPEAT=0, since the press was not consumed.
//   Launched slot must show slot_active=1 within COOLDOWN frames. The bullet takes 1 frame,
//     so the same slot is never double-allocated.
//   slot_active falling in the same frame as the search counts as free that frame.
//   launch is never multi-hot; launch_X/Y hold their last value while launch=0.
// TESTING
//   T1 reset, all slots free, space on keycode[7:0], ship=(320,400) -> launch=4'b0001 one frame,
//      launch_X/Y=320/400, shots_fired=1, state COOLDOWN for 6 frames.
//   T2 hold space, AUTO_REPEAT=0 -> no second launch; release 1 frame then press after cooldown
//      -> launch=4'b0010 (round-robin).
//   T3 AUTO_REPEAT=1, hold space 30 frames, slots free when launched -> launches every 7 frames:
//      0001,0010,0100,1000,0001.
//   T4 slot_active=4'b1111 with space held -> launch=0 and fire_ready=0. Drop slot_active[2]
//      -> launch=4'b0100 next edge.
//   T5 ship_Y=15 with space -> no launch. ship_Y=16 -> launch. Space on keycode[23:16] also fires.
//   T6 assert Reset during LAUNCH -> launch=0 immediately, shots_fired=0, next press fires slot 0.

Source files
------------

// File: rtl/bullet_fire_ctrl.sv
// Fire scheduler for a pool of bullet slots. SPACE requests are gated by a cooldown
// timer, press/release arming and a round-robin search for a free slot.
//
// state    | meaning
// IDLE     | waiting for a qualifying fire request
// LAUNCH   | one-hot launch strobe high for exactly one frame
// COOLDOWN | cool_cnt counts down; the cool_cnt==0 frame may fire again
module bullet_fire_ctrl #(
  parameter int         NUM_SLOTS   = 4,
  parameter int         COOLDOWN    = 6,
  parameter int         Y_MIN       = 15,
  parameter logic [7:0] SPACE_CODE  = 8'h2c,
  parameter bit         AUTO_REPEAT = 1'b0
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [23:0]          keycode,
  input  logic [9:0]           ship_X,
  input  logic [9:0]           ship_Y,
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [9:0]           launch_X,
  output logic [9:0]           launch_Y,
  output logic                 fire_ready,
  output logic [7:0]           shots_fired
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(COOLDOWN);

  typedef enum logic [1:0] {IDLE, LAUNCH, COOLDOWN_ST} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] cool_cnt;
  logic          armed;

  logic          space;
  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;
  logic [PW-1:0] next_ptr;
  logic          can_fire;
  logic          fire;

  assign space = (keycode[7:0] == SPACE_CODE) || (keycode[15:8] == SPACE_CODE) ||
                 (keycode[23:16] == SPACE_CODE);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_SLOTS);
      if (!found && !slot_active[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign next_ptr = PW'((int'(sel) + 1) % NUM_SLOTS);

  // The last cooldown frame doubles as the IDLE decision, giving a 1+COOLDOWN frame fire period.
  assign can_fire   = (state == IDLE) || ((state == COOLDOWN_ST) && (cool_cnt == '0));
  assign fire       = can_fire && space && armed && found && (ship_Y > 10'(Y_MIN));
  assign fire_ready = (state == IDLE) && found;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      launch      <= '0;
      launch_X    <= '0;
      launch_Y    <= '0;
      rr_ptr      <= '0;
      armed       <= 1'b1;
      cool_cnt    <= '0;
      shots_fired <= '0;
    end else begin
      if (AUTO_REPEAT)
        armed <= 1'b1;
      else if (fire)
        armed <= 1'b0;
      else if (!space)
        armed <= 1'b1;

      launch <= '0;
      if (fire) begin
        state       <= LAUNCH;
        launch      <= NUM_SLOTS'(1) << sel;
        launch_X    <= ship_X;
        launch_Y    <= ship_Y;
        rr_ptr      <= next_ptr;
        shots_fired <= shots_fired + 8'd1;
      end else begin
        case (state)
          LAUNCH: begin
            state    <= COOLDOWN_ST;
            cool_cnt <= CW'(COOLDOWN - 1);
          end
          COOLDOWN_ST: begin
            if (cool_cnt == '0)
              state <= IDLE;
            else
              cool_cnt <= cool_cnt - CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Scoreboard bench for bullet_fire_ctrl: stimulus queues expected launches, monitors
// pop and compare them whenever a DUT raises launch.
module tb_bullet_fire_ctrl;
  logic        frame_clk = 1'b0;
  logic        Reset, rst_ar;
  logic [23:0] keycode;
  logic [9:0]  ship_X, ship_Y;
  logic [3:0]  slot_active;
  logic [3:0]  launch, launch_a;
  logic [9:0]  launch_X, launch_Y, launch_X_a, launch_Y_a;
  logic        fire_ready, fire_ready_a;
  logic [7:0]  shots_fired, shots_fired_a;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] l;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] s;
    int         at;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  bullet_fire_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .ship_X(ship_X),
    .ship_Y(ship_Y), .slot_active(slot_active), .launch(launch), .launch_X(launch_X),
    .launch_Y(launch_Y), .fire_ready(fire_ready), .shots_fired(shots_fired)
  );

  bullet_fire_ctrl #(.AUTO_REPEAT(1'b1)) dut_ar (
    .frame_clk(frame_clk), .Reset(rst_ar), .keycode(keycode), .ship_X(ship_X),
    .ship_Y(ship_Y), .slot_active(slot_active), .launch(launch_a), .launch_X(launch_X_a),
    .launch_Y(launch_Y_a), .fire_ready(fire_ready_a), .shots_fired(shots_fired_a)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cmp_item(string nm, item_t g, item_t e);
    n_chk++;
    if (g.l === e.l && g.x === e.x && g.y === e.y && g.s === e.s && g.at == e.at)
      n_pass++;
    else
      $display("FAIL %s: got launch=%b X=%0d Y=%0d shots=%0d frame=%0d, expected launch=%b X=%0d Y=%0d shots=%0d frame=%0d",
               nm, g.l, g.x, g.y, g.s, g.at, e.l, e.x, e.y, e.s, e.at);
  endtask

  // Called on a negedge: the qualifying request is sampled on the very next posedge.
  task automatic exp0(logic [3:0] l, logic [9:0] x, logic [9:0] y, logic [7:0] s);
    q0.push_back('{l, x, y, s, cyc + 1});
  endtask

  task automatic step(int n);
    repeat (n) @(negedge frame_clk);
  endtask

  initial forever begin
    @(posedge frame_clk);
    #1;
    if (launch !== 4'b0) begin
      item_t g;
      g = '{launch, launch_X, launch_Y, shots_fired, cyc};
      if (q0.size() == 0) chk("dut unexpected launch", 32'(launch), 32'd0);
      else cmp_item("dut launch", g, q0.pop_front());
    end
  end

  initial forever begin
    @(posedge frame_clk);
    #1;
    if (launch_a !== 4'b0) begin
      item_t g;
      g = '{launch_a, launch_X_a, launch_Y_a, shots_fired_a, cyc};
      if (q1.size() == 0) chk("dut_ar unexpected launch", 32'(launch_a), 32'd0);
      else cmp_item("dut_ar launch", g, q1.pop_front());
    end
  end

  initial begin
    int c;
    Reset = 1'b1;
    rst_ar = 1'b1;
    keycode = '0;
    ship_X = 10'd320;
    ship_Y = 10'd400;
    slot_active = '0;
    step(2);
    chk("reset launch", 32'(launch), 32'd0);
    chk("reset launch_X", 32'(launch_X), 32'd0);
    chk("reset launch_Y", 32'(launch_Y), 32'd0);
    chk("reset shots", 32'(shots_fired), 32'd0);
    chk("reset fire_ready", 32'(fire_ready), 32'd1);
    Reset = 1'b0;
    step(1);

    // T1: first shot, then cooldown visible through fire_ready
    keycode = 24'h00002c;
    exp0(4'b0001, 10'd320, 10'd400, 8'd1);
    step(1);
    chk("t1 ready in launch", 32'(fire_ready), 32'd0);
    step(6);
    chk("t1 ready last cooldown", 32'(fire_ready), 32'd0);
    step(1);
    chk("t1 ready back in idle", 32'(fire_ready), 32'd1);
    step(4);
    chk("t1 shots held space", 32'(shots_fired), 32'd1);

    // T2: release one frame, press again -> next slot; launch_X/Y hold afterwards
    keycode = '0;
    step(1);
    keycode = 24'h00002c;
    ship_X = 10'd100;
    ship_Y = 10'd200;
    exp0(4'b0010, 10'd100, 10'd200, 8'd2);
    step(1);
    ship_X = 10'd555;
    ship_Y = 10'd300;
    step(1);
    chk("t2 launch_X hold", 32'(launch_X), 32'd100);
    chk("t2 launch_Y hold", 32'(launch_Y), 32'd200);
    chk("t2 launch one frame", 32'(launch), 32'd0);
    keycode = '0;
    step(10);

    // T4: all slots busy with space held, then slot 2 frees
    slot_active = 4'b1111;
    keycode = 24'h00002c;
    step(3);
    chk("t4 ready all busy", 32'(fire_ready), 32'd0);
    chk("t4 shots all busy", 32'(shots_fired), 32'd2);
    slot_active = 4'b1011;
    exp0(4'b0100, 10'd555, 10'd300, 8'd3);
    step(1);
    keycode = '0;
    slot_active = '0;
    step(10);

    // T5: Y threshold boundary, non-space codes, space in upper and middle bytes
    ship_Y = 10'd15;
    keycode = 24'h00002c;
    step(3);
    chk("t5 ready at y_min", 32'(fire_ready), 32'd1);
    chk("t5 shots at y_min", 32'(shots_fired), 32'd3);
    ship_Y = 10'd16;
    exp0(4'b1000, 10'd555, 10'd16, 8'd4);
    step(1);
    keycode = 24'h1a2b3d;
    step(10);
    keycode = 24'h2c0000;
    exp0(4'b0001, 10'd555, 10'd16, 8'd5);
    step(1);
    keycode = '0;
    step(10);
    keycode = 24'h002c00;
    exp0(4'b0010, 10'd555, 10'd16, 8'd6);
    step(1);
    keycode = '0;
    step(10);

    // T6: reset while launch is high
    ship_X = 10'd7;
    ship_Y = 10'd50;
    keycode = 24'h00002c;
    exp0(4'b0100, 10'd7, 10'd50, 8'd7);
    step(1);
    Reset = 1'b1;
    #1;
    chk("t6 launch on reset", 32'(launch), 32'd0);
    chk("t6 shots on reset", 32'(shots_fired), 32'd0);
    chk("t6 launch_X on reset", 32'(launch_X), 32'd0);
    keycode = '0;
    step(1);
    Reset = 1'b0;
    step(1);
    keycode = 24'h00002c;
    exp0(4'b0001, 10'd7, 10'd50, 8'd1);
    step(1);
    keycode = '0;
    step(10);

    // T3: auto-repeat instance, space held 30 frames -> a launch every 7 frames
    Reset = 1'b1;
    rst_ar = 1'b0;
    ship_X = 10'd320;
    ship_Y = 10'd400;
    step(1);
    chk("t3 ar ready after reset", 32'(fire_ready_a), 32'd1);
    keycode = 24'h00002c;
    c = cyc;
    q1.push_back('{4'b0001, 10'd320, 10'd400, 8'd1, c + 1});
    q1.push_back('{4'b0010, 10'd320, 10'd400, 8'd2, c + 8});
    q1.push_back('{4'b0100, 10'd320, 10'd400, 8'd3, c + 15});
    q1.push_back('{4'b1000, 10'd320, 10'd400, 8'd4, c + 22});
    q1.push_back('{4'b0001, 10'd320, 10'd400, 8'd5, c + 29});
    step(30);
    keycode = '0;
    step(2);
    rst_ar = 1'b1;
    step(2);

    chk("dut launches outstanding", 32'(q0.size()), 32'd0);
    chk("dut_ar launches outstanding", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
